// File: rtl/usb_bus_initiator_pkg.sv
// Shared definitions for the SAM3U-style parallel register bus initiator and its responder bench.
// Holds state encodings, default timing and the idle level of the four active-low control lines.
package usb_bus_initiator_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ALE    = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_STROBE = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_ALE    = S_ALE,
      ST_SETUP  = S_SETUP,
      ST_STROBE = S_STROBE,
      ST_HOLD   = S_HOLD,
      ST_DONE   = S_DONE
   } state_t;

   localparam int DEF_ALE_CYCLES    = 2;
   localparam int DEF_SETUP_CYCLES  = 1;
   localparam int DEF_STROBE_CYCLES = 3;
   localparam int DEF_HOLD_CYCLES   = 1;
   localparam int DEF_CNT_W         = 4;

   // Bit order {alen, cen, rdn, wrn}
   localparam logic [3:0] BUS_IDLE = 4'b1111;

   function automatic logic in_burst(input state_t st);
      return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_HOLD);
   endfunction

endpackage

// File: rtl/usb_bus_initiator_timer.sv
// Loadable down-counter shared by all timed bus phases; expired_o is high once the count reaches zero.
module usb_bus_initiator_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;

   // Count register: load on phase entry, otherwise count down and park at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != {CNT_W{1'b0}}) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign expired_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/usb_bus_initiator.sv
// Burst initiator for the 8-bit parallel register bus: address latch, chip enable and per-byte strobes.
// All outputs are registered and decoded from the next state, so bus pins never see input glitches.
module usb_bus_initiator
   import usb_bus_initiator_pkg::*;
#(
   parameter int ALE_CYCLES    = DEF_ALE_CYCLES,
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [15:0] cmd_len,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        done,
   output logic [7:0]  bus_addr,
   output logic [7:0]  bus_data_o,
   output logic        bus_data_oe,
   input  logic [7:0]  bus_data_i,
   output logic        bus_alen,
   output logic        bus_cen,
   output logic        bus_rdn,
   output logic        bus_wrn
);

   state_t      state_q, state_d;
   logic        wr_q;
   logic [15:0] rem_q, rem_d;
   logic [3:0]  ctl_q, ctl_d;
   logic [7:0]  bus_addr_q, bus_addr_d;
   logic [7:0]  bus_data_o_q, bus_data_o_d;
   logic        oe_q, oe_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        wr_ready_q, done_q, cmd_ready_q;
   logic        take_cmd_s, take_wr_s, end_strobe_s;
   logic        tmr_load_s, tmr_expired_s;
   logic [CNT_W-1:0] tmr_val_s;

   usb_bus_initiator_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .expired_o  (tmr_expired_s)
   );

   // Next-state logic and the strobes that qualify data movement
   always_comb begin
      state_d      = state_q;
      take_cmd_s   = 1'b0;
      take_wr_s    = 1'b0;
      end_strobe_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               take_cmd_s = 1'b1;
               state_d    = (cmd_len == 16'd0) ? ST_DONE : ST_ALE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ALE: begin
            state_d = tmr_expired_s ? ST_SETUP : ST_ALE;
         end
         ST_SETUP: begin
            if (tmr_expired_s && (!wr_q || wr_valid)) begin
               take_wr_s = wr_q;
               state_d   = ST_STROBE;
            end else begin
               state_d = ST_SETUP;
            end
         end
         ST_STROBE: begin
            end_strobe_s = tmr_expired_s;
            state_d      = tmr_expired_s ? ST_HOLD : ST_STROBE;
         end
         ST_HOLD: begin
            // A read byte must be consumed before the next strobe may overwrite it
            if (tmr_expired_s && (wr_q || !rd_valid_q || rd_ready)) begin
               state_d = (rem_q != 16'd0) ? ST_SETUP : ST_DONE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Timer reload on every phase change, with the phase length minus one
   always_comb begin
      tmr_load_s = (state_d != state_q);
      case (state_d)
         ST_ALE:    tmr_val_s = CNT_W'(ALE_CYCLES - 1);
         ST_SETUP:  tmr_val_s = CNT_W'(SETUP_CYCLES - 1);
         ST_STROBE: tmr_val_s = CNT_W'(STROBE_CYCLES - 1);
         ST_HOLD:   tmr_val_s = CNT_W'(HOLD_CYCLES - 1);
         default:   tmr_val_s = {CNT_W{1'b0}};
      endcase
   end

   // Output and datapath next values
   always_comb begin
      ctl_d = {~(state_d == ST_ALE),
               ~in_burst(state_d),
               ~((state_d == ST_STROBE) && !wr_q),
               ~((state_d == ST_STROBE) && wr_q)};
      oe_d         = wr_q && in_burst(state_d);
      bus_addr_d   = (take_cmd_s && (cmd_len != 16'd0)) ? cmd_addr : bus_addr_q;
      bus_data_o_d = take_wr_s ? wr_data : bus_data_o_q;
      rem_d        = take_cmd_s ? cmd_len : (end_strobe_s ? rem_q - 16'd1 : rem_q);
      rd_data_d    = (end_strobe_s && !wr_q) ? bus_data_i : rd_data_q;
      if (end_strobe_s && !wr_q) begin
         rd_valid_d = 1'b1;
      end else if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
      end else begin
         rd_valid_d = rd_valid_q;
      end
   end

   // State and registered outputs; reset forces the bus to idle levels at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         wr_q         <= 1'b0;
         rem_q        <= 16'd0;
         ctl_q        <= BUS_IDLE;
         oe_q         <= 1'b0;
         bus_addr_q   <= 8'd0;
         bus_data_o_q <= 8'd0;
         rd_data_q    <= 8'd0;
         rd_valid_q   <= 1'b0;
         wr_ready_q   <= 1'b0;
         done_q       <= 1'b0;
         cmd_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_q         <= take_cmd_s ? cmd_write : wr_q;
         rem_q        <= rem_d;
         ctl_q        <= ctl_d;
         oe_q         <= oe_d;
         bus_addr_q   <= bus_addr_d;
         bus_data_o_q <= bus_data_o_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         wr_ready_q   <= take_wr_s;
         done_q       <= (state_d == ST_DONE);
         cmd_ready_q  <= (state_d == ST_IDLE);
      end
   end

   assign {bus_alen, bus_cen, bus_rdn, bus_wrn} = ctl_q;
   assign bus_data_oe = oe_q;
   assign bus_addr    = bus_addr_q;
   assign bus_data_o  = bus_data_o_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign wr_ready    = wr_ready_q;
   assign done        = done_q;
   assign cmd_ready   = cmd_ready_q;

endmodule
